// File: rtl/axil_ctrl_regs_if.sv
// AXI-Lite bus bundle for the control register block.
// master: drives aw/w/ar channels and b/r ready; slave: drives the rest.
interface axil_ctrl_regs_if #(
    parameter int ADDR_W = 12
) ();
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_ctrl_regs.sv
// AXI-Lite control/status register file with byte strobes and hw clear.
// Ports: clk, rst (async high), s_axil (slave), reg_out, status_in, clr_in, wr_pulse.
module axil_ctrl_regs #(
    parameter int                  NUM_REGS = 8,
    parameter int                  ADDR_W   = 12,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    axil_ctrl_regs_if.slave         s_axil,
    output logic [NUM_REGS*32-1:0]  reg_out,
    input  logic [NUM_REGS*32-1:0]  status_in,
    input  logic [NUM_REGS*32-1:0]  clr_in,
    output logic [NUM_REGS-1:0]     wr_pulse
);
    localparam int          IDX_W = ADDR_W - 2;
    localparam int          LOC_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] NREG  = 32'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RDATA
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_aw_idx;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic [1:0]       r_bresp;
    logic [1:0]       r_rresp;
    logic [31:0]      r_rdata;
    logic [31:0]      r_regs [NUM_REGS];

    logic             w_commit;
    logic [IDX_W-1:0] w_idx;
    logic [LOC_W-1:0] w_loc;
    logic [31:0]      w_data;
    logic [3:0]       w_strb;
    logic             w_hit;
    logic             w_we;
    logic [IDX_W-1:0] w_ar_idx;
    logic [LOC_W-1:0] w_ar_loc;
    logic             w_ar_in;
    logic [31:0]      w_rd_data;
    logic             w_unused;

    // Low address bits select bytes within a word and are not decoded.
    assign w_unused = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0]};

    // The half captured earlier comes from the holding registers,
    // the half completing now comes straight off the bus.
    assign w_commit = (r_state == S_IDLE  && s_axil.awvalid && s_axil.wvalid)
                   || (r_state == S_WADDR && s_axil.wvalid)
                   || (r_state == S_WDATA && s_axil.awvalid);
    assign w_idx  = (r_state == S_WADDR) ? r_aw_idx
                                         : s_axil.awaddr[ADDR_W-1:2];
    assign w_data = (r_state == S_WDATA) ? r_wdata : s_axil.wdata;
    assign w_strb = (r_state == S_WDATA) ? r_wstrb : s_axil.wstrb;
    assign w_loc  = w_idx[LOC_W-1:0];
    assign w_hit  = (32'(w_idx) < NREG) && !RO_MASK[w_loc];
    assign w_we   = w_commit && w_hit;

    assign w_ar_idx = s_axil.araddr[ADDR_W-1:2];
    assign w_ar_loc = w_ar_idx[LOC_W-1:0];
    assign w_ar_in  = 32'(w_ar_idx) < NREG;

    always_comb begin
        w_rd_data = '0;
        if (w_ar_in) begin
            if (RO_MASK[w_ar_loc])
                w_rd_data = status_in[32*w_ar_loc +: 32];
            else
                w_rd_data = r_regs[w_ar_loc];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_aw_idx <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= '0;
            r_rresp  <= '0;
            r_rdata  <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (w_commit) begin
                r_bresp <= w_hit ? 2'b00 : 2'b10;
                if (w_hit && (|w_strb))
                    wr_pulse[w_loc] <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (s_axil.awvalid && s_axil.wvalid) begin
                        r_state <= S_WRESP;
                    end else if (s_axil.awvalid) begin
                        r_aw_idx <= s_axil.awaddr[ADDR_W-1:2];
                        r_state  <= S_WADDR;
                    end else if (s_axil.wvalid) begin
                        r_wdata <= s_axil.wdata;
                        r_wstrb <= s_axil.wstrb;
                        r_state <= S_WDATA;
                    end else if (s_axil.arvalid) begin
                        r_rdata <= w_rd_data;
                        r_rresp <= w_ar_in ? 2'b00 : 2'b10;
                        r_state <= S_RDATA;
                    end
                end
                S_WADDR: if (s_axil.wvalid)  r_state <= S_WRESP;
                S_WDATA: if (s_axil.awvalid) r_state <= S_WRESP;
                S_WRESP: if (s_axil.bready)  r_state <= S_IDLE;
                S_RDATA: if (s_axil.rready)  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Written bytes win over a same-cycle clear; RO slots stay zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++)
                r_regs[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if (RO_MASK[k])
                        r_regs[k][8*b +: 8] <= '0;
                    else if (w_we && (w_loc == LOC_W'(k)) && w_strb[b])
                        r_regs[k][8*b +: 8] <= w_data[8*b +: 8];
                    else
                        r_regs[k][8*b +: 8] <= r_regs[k][8*b +: 8]
                                             & ~clr_in[32*k + 8*b +: 8];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign reg_out[32*k +: 32] = r_regs[k];
    end

    assign s_axil.awready = (r_state == S_IDLE) || (r_state == S_WDATA);
    assign s_axil.wready  = (r_state == S_IDLE) || (r_state == S_WADDR);
    assign s_axil.arready = (r_state == S_IDLE);
    assign s_axil.bvalid  = (r_state == S_WRESP);
    assign s_axil.rvalid  = (r_state == S_RDATA);
    assign s_axil.bresp   = r_bresp;
    assign s_axil.rresp   = r_rresp;
    assign s_axil.rdata   = r_rdata;
endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Testbench for axil_ctrl_regs: random AXI-Lite traffic against a register model.
// Responses are queued at issue time and compared by an independent monitor.
module tb_axil_ctrl_regs;
    localparam int         NR  = 8;
    localparam int         AW  = 12;
    localparam logic [7:0] ROM = 8'h80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_ctrl_regs_if #(.ADDR_W(AW)) bus ();
    logic [NR*32-1:0] reg_out;
    logic [NR*32-1:0] status_in;
    logic [NR*32-1:0] clr_in;
    logic [NR-1:0]    wr_pulse;

    axil_ctrl_regs #(.NUM_REGS(NR), .ADDR_W(AW), .RO_MASK(ROM)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_axil   (bus),
        .reg_out  (reg_out),
        .status_in(status_in),
        .clr_in   (clr_in),
        .wr_pulse (wr_pulse)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mregs [NR];
    logic [31:0] mstat [NR];

    typedef struct { logic [1:0] resp; logic [7:0] pulse; } bexp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
    bexp_t bq[$];
    rexp_t rq[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: clear first, then strobed bytes of a legal write.
    task automatic mwrite(input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [NR*32-1:0] clr);
        int  idx;
        bit  ok;
        bexp_t e;
        for (int k = 0; k < NR; k++)
            if (!ROM[k]) mregs[k] = mregs[k] & ~clr[32*k +: 32];
        idx = int'(a[11:2]);
        ok  = (idx < NR) && !ROM[idx];
        if (ok)
            for (int b = 0; b < 4; b++)
                if (s[b]) mregs[idx][8*b +: 8] = d[8*b +: 8];
        e.resp  = ok ? 2'b00 : 2'b10;
        e.pulse = (ok && s != 4'h0) ? 8'(1 << idx) : 8'h00;
        bq.push_back(e);
    endtask

    task automatic mread(input logic [11:0] a);
        int    idx;
        rexp_t e;
        idx = int'(a[11:2]);
        if (idx >= NR) begin
            e.data = 32'h0; e.resp = 2'b10;
        end else if (ROM[idx]) begin
            e.data = mstat[idx]; e.resp = 2'b00;
        end else begin
            e.data = mregs[idx]; e.resp = 2'b00;
        end
        rq.push_back(e);
    endtask

    task automatic check_regs();
        for (int k = 0; k < NR; k++)
            chk($sformatf("reg_out[%0d]", k), 64'(reg_out[32*k +: 32]),
                64'(mregs[k]));
    endtask

    // which: 0 aw, 1 w, 2 aw+w, 3 ar. Returns just after the handshake edge.
    task automatic wait_hs(input int which);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            case (which)
                0: done = bus.awready;
                1: done = bus.wready;
                2: done = bus.awready && bus.wready;
                default: done = bus.arready;
            endcase
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL handshake %0d: got timeout expected ready", which);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (bq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0",
                     bq.size() + rq.size());
            bq.delete();
            rq.delete();
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int mode, input int gap,
                            input int bdly, input logic [NR*32-1:0] clr);
        mwrite(a, d, s, clr);
        bus.bready = (bdly == 0);
        if (mode == 0) begin
            bus.awaddr = a; bus.awvalid = 1'b1;
            bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
            clr_in = clr;
            wait_hs(2);
            bus.awvalid = 1'b0; bus.wvalid = 1'b0; clr_in = '0;
        end else begin
            if (mode == 1) begin
                bus.awaddr = a; bus.awvalid = 1'b1;
                wait_hs(0);
                bus.awvalid = 1'b0;
            end else begin
                bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
                wait_hs(1);
                bus.wvalid = 1'b0;
            end
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                chk("no_early_bvalid", 64'(bus.bvalid), 64'd0);
                tick();
            end
            clr_in = clr;
            if (mode == 1) begin
                bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
                wait_hs(1);
                bus.wvalid = 1'b0;
            end else begin
                bus.awaddr = a; bus.awvalid = 1'b1;
                wait_hs(0);
                bus.awvalid = 1'b0;
            end
            clr_in = '0;
        end
        if (bdly > 0) begin
            for (int i = 0; i < bdly; i++) begin
                @(negedge clk);
                chk("bvalid_hold", 64'(bus.bvalid), 64'd1);
            end
            tick();
            bus.bready = 1'b1;
        end
        drain();
        check_regs();
    endtask

    task automatic do_read(input logic [11:0] a, input int rdly);
        mread(a);
        bus.rready = (rdly == 0);
        bus.araddr = a;
        bus.arvalid = 1'b1;
        wait_hs(3);
        bus.arvalid = 1'b0;
        if (rdly > 0) begin
            for (int i = 0; i < rdly; i++) begin
                @(negedge clk);
                chk("rvalid_hold", 64'(bus.rvalid), 64'd1);
            end
            tick();
            bus.rready = 1'b1;
        end
        drain();
    endtask

    task automatic do_clr(input logic [NR*32-1:0] clr);
        for (int k = 0; k < NR; k++)
            if (!ROM[k]) mregs[k] = mregs[k] & ~clr[32*k +: 32];
        clr_in = clr;
        tick();
        clr_in = '0;
        check_regs();
    endtask

    // Monitor: pops expected responses whenever the DUT completes one.
    logic  prev_bv = 1'b0;
    bexp_t mb;
    rexp_t mr;
    always @(negedge clk) begin
        if (rst) begin
            prev_bv <= 1'b0;
        end else begin
            if (bus.bvalid && !prev_bv && bq.size() != 0)
                chk("wr_pulse_first", 64'(wr_pulse), 64'(bq[0].pulse));
            else
                chk("wr_pulse_idle", 64'(wr_pulse), 64'd0);
            if (bus.bvalid && bus.bready) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bresp: got unexpected response expected none");
                end else begin
                    mb = bq.pop_front();
                    chk("bresp", 64'(bus.bresp), 64'(mb.resp));
                end
            end
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata: got unexpected response expected none");
                end else begin
                    mr = rq.pop_front();
                    chk("rdata", 64'(bus.rdata), 64'(mr.data));
                    chk("rresp", 64'(bus.rresp), 64'(mr.resp));
                end
            end
            prev_bv <= bus.bvalid;
        end
    end

    logic [NR*32-1:0] rclr;
    logic [31:0]      d;

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        clr_in = '0;
        for (int k = 0; k < NR; k++) begin
            mregs[k] = '0;
            mstat[k] = $urandom;
        end
        mstat[7] = 32'h5A5A0001;
        for (int k = 0; k < NR; k++)
            status_in[32*k +: 32] = mstat[k];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_wr_pulse", 64'(wr_pulse), 64'd0);
        check_regs();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {61'd0, bus.awready, bus.wready, bus.arready},
            64'd7);
        tick();

        do_write(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0, '0);
        chk("simul_write", 64'(reg_out[63:32]), 64'hDEADBEEF);

        do_write(12'h000, 32'h11223344, 4'hF, 0, 0, 0, '0);
        do_write(12'h000, 32'h0000AB00, 4'h2, 1, 3, 0, '0);
        chk("strobe_merge", 64'(reg_out[31:0]), 64'h1122AB44);

        do_write(12'h020, 32'h12345678, 4'hF, 0, 0, 0, '0);
        do_read(12'h020, 0);

        do_read(12'h01C, 0);
        do_write(12'h01C, 32'hFFFFFFFF, 4'hF, 2, 1, 0, '0);
        chk("ro_reg_out", 64'(reg_out[255:224]), 64'd0);

        do_write(12'h000, 32'h00000007, 4'hF, 0, 0, 0, '0);
        do_clr(256'h1);
        chk("hw_clear", 64'(reg_out[31:0]), 64'h6);
        do_write(12'h000, 32'h00000001, 4'hF, 0, 0, 0, 256'h1);
        chk("clear_vs_write", 64'(reg_out[31:0]), 64'h1);
        do_write(12'h000, 32'h0000FF00, 4'h2, 1, 2, 0, 256'h0000_0101);

        // Write and read offered together: write wins, read waits.
        mwrite(12'h018, 32'hA5A5_0F0F, 4'hF, '0);
        mread(12'h018);
        bus.awaddr = 12'h018; bus.awvalid = 1'b1;
        bus.wdata = 32'hA5A5_0F0F; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 12'h018; bus.arvalid = 1'b1;
        wait_hs(2);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        chk("ar_blocked", 64'(bus.arready), 64'd0);
        tick();
        wait_hs(3);
        bus.arvalid = 1'b0;
        drain();
        check_regs();

        do_write(12'h008, 32'h0BAD_F00D, 4'hF, 0, 0, 4, '0);

        // Reset while an address is held.
        bus.awaddr = 12'h00C; bus.awvalid = 1'b1;
        wait_hs(0);
        bus.awvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_awready", 64'(bus.awready), 64'd1);
        for (int k = 0; k < NR; k++) mregs[k] = '0;
        check_regs();
        tick();
        rst = 1'b0;
        do_write(12'h010, 32'hCAFE0001, 4'hF, 2, 3, 0, '0);

        for (int it = 0; it < 80; it++) begin
            int op;
            logic [11:0] a;
            op = $urandom_range(0, 9);
            a  = 12'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
            d  = $urandom;
            rclr = '0;
            if (op >= 8)
                for (int k = 0; k < NR; k++)
                    rclr[32*k +: 32] = $urandom & $urandom;
            if (op <= 4)
                do_write(a, d, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 2), $urandom_range(0, 3),
                         $urandom_range(0, 2), '0);
            else if (op <= 7)
                do_read(a, $urandom_range(0, 2));
            else if (op == 8)
                do_clr(rclr);
            else
                do_write(a, d, 4'($urandom_range(1, 15)),
                         $urandom_range(0, 2), $urandom_range(0, 2), 0, rclr);
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axil_ctrl_regs.md
AXIL_CTRL_REGS -- requirements
Module: axil_ctrl_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of 32-bit registers (1..256).
REQ-002 SHALL have parameter ADDR_W, default 12, AXI-Lite address width used for decode.
REQ-003 SHALL have parameter RO_MASK [NUM_REGS], default 0, where bit k=1 makes register k read-only status.
REQ-004 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-005 SHALL have AXI-Lite write ports: awaddr in ADDR_W; awvalid in 1; awready out 1; wdata in 32; wstrb in 4; wvalid in 1; wready out 1; bresp out 2; bvalid out 1; bready in 1.
REQ-006 SHALL have AXI-Lite read ports: araddr in ADDR_W; arvalid in 1; arready out 1; rdata out 32; rresp out 2; rvalid out 1; rready in 1.
REQ-007 SHALL have reg_out out NUM_REGS*32, the current contents of all registers (register k at bits [32k+31:32k]).
REQ-008 SHALL have status_in in NUM_REGS*32, the read value for RO registers.
REQ-009 SHALL have clr_in in NUM_REGS*32, per-bit hardware clear requests (e.g. auto-clear of a start bit).
REQ-010 SHALL have wr_pulse out NUM_REGS, a one-cycle strobe marking a committed write to register k.

Function
REQ-011 SHALL implement states IDLE, WADDR (address held, data pending), WDATA (data held, address pending), WRESP and RDATA.
REQ-012 SHALL drive awready=IDLE|WDATA, wready=IDLE|WADDR, arready=IDLE, bvalid=WRESP and rvalid=RDATA.
REQ-013 In IDLE, awvalid&wvalid SHALL capture both and go to WRESP; awvalid only SHALL go to WADDR; wvalid only SHALL go to WDATA; otherwise arvalid SHALL go to RDATA.
REQ-014 Writes SHALL have priority over reads when both are valid in IDLE; the read SHALL stay pending (arready=0 outside IDLE).
REQ-015 Index SHALL be addr[ADDR_W-1:2]; addr[1:0] SHALL be ignored.
REQ-016 A write SHALL commit on the edge that enters WRESP, updating only bytes whose wstrb bit is 1; wstrb=0 SHALL commit nothing but still respond OKAY.
REQ-017 wr_pulse[k] SHALL be 1 for exactly the first WRESP cycle of a committed write to writable register k, and 0 otherwise.
REQ-018 Index>=NUM_REGS or RO_MASK[k]=1 SHALL give bresp=2'b10 (SLVERR), with no register change and no wr_pulse; otherwise bresp=2'b00.
REQ-019 WRESP SHALL hold until bready=1, then return to IDLE; the next transaction SHALL be accepted no earlier than the following cycle.
REQ-020 On the read handshake, rdata/rresp SHALL be registered on the same edge, so rvalid rises one cycle after arvalid&arready.
REQ-021 rdata SHALL be the register for a writable k, status_in slice k for an RO k, and 0 with rresp=2'b10 for index>=NUM_REGS.
REQ-022 rdata/rresp SHALL stay stable while rvalid=1 and rready=0; RDATA SHALL return to IDLE on rready=1.
REQ-023 Each cycle, register bits with clr_in=1 SHALL clear to 0, except that bytes written in that same cycle SHALL take the written value.
REQ-024 reg_out SHALL reflect committed values one cycle after commit or clear; RO registers SHALL read 0 on reg_out.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE and clear all registers, bvalid, rvalid, bresp, rresp, rdata and wr_pulse to 0.
REQ-026 rst asserted mid-transaction SHALL abandon the transaction with no commit and no response.
REQ-027 After rst deasserts, awready/wready/arready SHALL be 1 on the first clock.

Verification
REQ-028 Simultaneous aw/w to 0x004 with data 0xDEADBEEF and wstrb=0xF -> bvalid next cycle, bresp=00, wr_pulse[1] for 1 cycle, reg_out[63:32]=0xDEADBEEF.
REQ-029 Address first, data 3 cycles later, wstrb=0x2 and data 0x0000AB00 to reg 0 holding 0x11223344 -> register becomes 0x1122AB44.
REQ-030 Write to 0x020 with NUM_REGS=8 -> bresp=10 and no change; read of 0x020 -> rdata=0, rresp=10.
REQ-031 RO_MASK=0x80, status_in reg 7=0x5A5A0001 -> read of 0x01C returns 0x5A5A0001; write returns SLVERR.
REQ-032 Reg 0=0x7 with clr_in bit0 pulsed for 1 cycle -> reg 0 reads 0x6; clr_in bit0 and a write of 0x1 in the same cycle -> reg 0 becomes 0x1.
REQ-033 Assert rst while in WADDR -> IDLE immediately; a later write of data alone does not commit stale address state; bready held 0 in WRESP keeps bvalid=1.
